// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Multi-cycle signed multiply/divide engine holding the architectural
//   HI/LO register pair. MULT uses radix-2 shift-add on operand magnitudes,
//   DIV uses restoring shift-subtract; the sign is applied in a final FIX
//   cycle. busy stalls the pipe while an operation is in flight.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      issue MULT/DIV (accepted only when idle)
//   alusignal  op code: 4'b1001 MULT, 4'b1111 DIV; other codes ignored
//   a, b       signed operands (multiplicand/dividend, multiplier/divisor)
//   flush      abort the in-flight operation
//   mthi_we    write wdata to HI (idle, no start)
//   mtlo_we    write wdata to LO (idle, no start)
//   wdata      MTHI/MTLO data
//   busy       operation in flight
//   done       one-cycle pulse when new HI/LO become visible
//   hi, lo     HI/LO registers
module hilo_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alusignal,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_MULT = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_div;
    logic                 r_dz;
    logic                 r_neg_res;     // sign of product / quotient
    logic                 r_neg_rem;     // sign of remainder (dividend sign)
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH:0]       r_mplier;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;         // dividend magnitude, becomes quotient
    logic [WIDTH:0]       r_dvsr;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;

    logic                 w_is_mult;
    logic                 w_is_div;
    logic                 w_accept;
    logic                 w_b_zero;
    logic [WIDTH:0]       w_a_ext;
    logic [WIDTH:0]       w_b_ext;
    logic [WIDTH:0]       w_a_mag;
    logic [WIDTH:0]       w_b_mag;
    logic [WIDTH:0]       w_shift;
    logic                 w_fits;
    logic [2*WIDTH-1:0]   w_prod_s;
    logic [WIDTH-1:0]     w_quo_s;
    logic [WIDTH-1:0]     w_rem_s;

    // Datapath combinational helpers
    always_comb begin
        w_is_mult = (alusignal == OP_MULT);
        w_is_div  = (alusignal == OP_DIV);
        w_accept  = (r_state == S_IDLE) && start && !flush && (w_is_mult || w_is_div);
        w_b_zero  = (b == '0);
        // Magnitudes in WIDTH+1 bits so |INT_MIN| is representable
        w_a_ext   = {a[WIDTH-1], a};
        w_b_ext   = {b[WIDTH-1], b};
        w_a_mag   = a[WIDTH-1] ? -w_a_ext : w_a_ext;
        w_b_mag   = b[WIDTH-1] ? -w_b_ext : w_b_ext;
        // Restoring division step: shift in next dividend bit, trial subtract
        w_shift   = {r_rem, r_quo[WIDTH-1]};
        w_fits    = (w_shift >= r_dvsr);
        w_prod_s  = r_neg_res ? -r_prod : r_prod;
        w_quo_s   = r_neg_res ? -r_quo  : r_quo;
        w_rem_s   = r_neg_rem ? -r_rem  : r_rem;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (w_is_div && w_b_zero) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy = (r_state != S_IDLE);
        done = r_done;
        hi   = r_hi;
        lo   = r_lo;
    end

    // Iteration datapath and HI/LO registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_dz      <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvsr    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            // FIX is the only state that publishes results; flush suppresses it
            r_done <= (r_state == S_FIX) && !flush;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt     <= '0;
                        r_is_div  <= w_is_div;
                        r_dz      <= w_is_div && w_b_zero;
                        r_neg_res <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg_rem <= a[WIDTH-1];
                        r_mcand   <= {{(WIDTH-1){1'b0}}, w_a_mag};
                        r_mplier  <= w_b_mag;
                        r_prod    <= '0;
                        r_rem     <= '0;
                        r_quo     <= w_a_mag[WIDTH-1:0];
                        r_dvsr    <= w_b_mag;
                    end else if (!start) begin
                        if (mthi_we) r_hi <= wdata;
                        if (mtlo_we) r_lo <= wdata;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!r_is_div) begin
                        if (r_mplier[0]) r_prod <= r_prod + r_mcand;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                    end else begin
                        r_rem <= w_fits ? WIDTH'(w_shift - r_dvsr) : w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_fits};
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        if (r_dz) begin
                            r_hi <= '0;
                            r_lo <= '0;
                        end else if (r_is_div) begin
                            r_hi <= w_rem_s;
                            r_lo <= w_quo_s;
                        end else begin
                            r_hi <= w_prod_s[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_s[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

    localparam int W = 32;
    localparam logic [3:0] MULT = 4'b1001;
    localparam logic [3:0] DIV  = 4'b1111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   alusignal;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         mthi_we;
    logic         mtlo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .alusignal (alusignal),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .mthi_we   (mthi_we),
        .mtlo_we   (mtlo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Transaction-level model: a countdown of remaining busy cycles plus
    // the architecturally expected result computed with 64-bit arithmetic.
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic [W-1:0] p_hi   = '0;
    logic [W-1:0] p_lo   = '0;

    task automatic model_step();
        longint sa, sb, t;
        bit     nd;
        nd = 1'b0;
        if (!rst_n) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
        end else if (m_left > 0) begin
            if (flush) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                    nd   = 1'b1;
                end
            end
        end else if (start && !flush && (alusignal == MULT || alusignal == DIV)) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            if (alusignal == MULT) begin
                t = sa * sb;
                p_hi = t[63:32];
                p_lo = t[31:0];
                m_left = W + 1;
            end else if (sb == 0) begin
                p_hi = '0;
                p_lo = '0;
                m_left = 1;
            end else begin
                t = sa / sb;
                p_lo = t[31:0];
                t = sa % sb;
                p_hi = t[31:0];
                m_left = W + 1;
            end
        end else if (!start) begin
            if (mthi_we) m_hi = wdata;
            if (mtlo_we) m_lo = wdata;
        end
        m_done = nd;
    endtask

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (busy !== (m_left > 0) || done !== m_done || hi !== m_hi || lo !== m_lo) begin
                miscompares++;
                $display("FAIL cycle t=%0t actual busy=%b done=%b hi=%h lo=%h required busy=%b done=%b hi=%h lo=%h",
                         $time, busy, done, hi, lo, (m_left > 0), m_done, m_hi, m_lo);
            end
        end
    end

    task automatic check_lit(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%h required=%h", nm, got, exp);
        end
    endtask

    task automatic set_idle();
        start = 1'b0; alusignal = 4'b0000; a = '0; b = '0;
        flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic start_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        set_idle();
        start = 1'b1; alusignal = op; a = x; b = y;
        tick();
        set_idle();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: busy actual=still high after %0d cycles required=low", n);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, output int n);
        start_op(op, x, y);
        wait_idle(n);
    endtask

    task automatic mt(input logic h, input logic l, input logic [W-1:0] d);
        set_idle();
        mthi_we = h; mtlo_we = l; wdata = d;
        tick();
        set_idle();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'(int'($urandom_range(0, 40)) - 20);
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int n;
        set_idle();
        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        check_lit("reset busy", W'(busy), '0);
        check_lit("reset done", W'(done), '0);
        check_lit("reset hi", hi, '0);
        check_lit("reset lo", lo, '0);
        rst_n = 1'b1;

        issue(MULT, 32'd7, 32'hFFFF_FFFD, n);
        check_lit("mult 7*-3 busy cycles", W'(n), 32'd33);
        check_lit("mult 7*-3 done", W'(done), 32'd1);
        check_lit("mult 7*-3 hi", hi, 32'hFFFF_FFFF);
        check_lit("mult 7*-3 lo", lo, 32'hFFFF_FFEB);

        issue(MULT, 32'h8000_0000, 32'h8000_0000, n);
        check_lit("mult min*min hi", hi, 32'h4000_0000);
        check_lit("mult min*min lo", lo, 32'h0);

        issue(DIV, 32'hFFFF_FFF9, 32'd2, n);
        check_lit("div -7/2 lo", lo, 32'hFFFF_FFFD);
        check_lit("div -7/2 hi", hi, 32'hFFFF_FFFF);

        issue(DIV, 32'd100, 32'd7, n);
        check_lit("div 100/7 lo", lo, 32'd14);
        check_lit("div 100/7 hi", hi, 32'd2);

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        check_lit("div min/-1 lo", lo, 32'h8000_0000);
        check_lit("div min/-1 hi", hi, 32'h0);

        issue(DIV, 32'd5, 32'd0, n);
        check_lit("div by zero busy cycles", W'(n), 32'd1);
        check_lit("div by zero done", W'(done), 32'd1);
        check_lit("div by zero hi", hi, 32'h0);
        check_lit("div by zero lo", lo, 32'h0);

        // start while busy ignored, MTLO while busy dropped
        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        check_lit("preset hi", hi, 32'h11);
        check_lit("preset lo", lo, 32'h22);
        start_op(MULT, 32'd3, 32'd4);
        for (int c = 2; c <= 12; c++) begin
            if (c == 10) begin start = 1'b1; alusignal = DIV; a = 32'd9; b = 32'd3; end
            if (c == 12) begin mtlo_we = 1'b1; wdata = 32'h55; end
            tick();
            set_idle();
        end
        wait_idle(n);
        check_lit("mult 3*4 hi", hi, 32'h0);
        check_lit("mult 3*4 lo", lo, 32'd12);

        // flush mid-operation
        mt(1'b1, 1'b1, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        start_op(MULT, 32'd6, 32'd6);
        for (int c = 2; c <= 14; c++) tick();
        flush = 1'b1;
        tick();
        set_idle();
        check_lit("flush busy", W'(busy), '0);
        check_lit("flush done", W'(done), '0);
        tick();
        check_lit("flush hi", hi, 32'h11);
        check_lit("flush lo", lo, 32'h22);

        // reset during a DIV
        start_op(DIV, 32'd50, 32'd5);
        for (int c = 0; c < 5; c++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_lit("mid reset busy", W'(busy), '0);
        check_lit("mid reset hi", hi, '0);
        check_lit("mid reset lo", lo, '0);

        mt(1'b1, 1'b0, 32'hDEAD_BEEF);
        check_lit("mthi", hi, 32'hDEAD_BEEF);
        mt(1'b0, 1'b1, 32'hCAFE_F00D);
        check_lit("mtlo", lo, 32'hCAFE_F00D);
        start_op(4'b0010, 32'd1, 32'd1);
        check_lit("bad op busy", W'(busy), '0);
        check_lit("bad op hi", hi, 32'hDEAD_BEEF);
        check_lit("bad op lo", lo, 32'hCAFE_F00D);

        mt(1'b1, 1'b1, 32'h1234);
        check_lit("mt both hi", hi, 32'h1234);
        check_lit("mt both lo", lo, 32'h1234);

        set_idle();
        start = 1'b1; alusignal = MULT; a = 32'd2; b = 32'd2; flush = 1'b1;
        tick();
        set_idle();
        check_lit("flush+start busy", W'(busy), '0);

        set_idle();
        start = 1'b1; alusignal = MULT; a = 32'd2; b = 32'd2; mthi_we = 1'b1; wdata = 32'hAAAA;
        tick();
        set_idle();
        wait_idle(n);
        check_lit("start beats mthi hi", hi, 32'h0);
        check_lit("start beats mthi lo", lo, 32'd4);

        // Randomized traffic, checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 4))
                0, 1:    alusignal = MULT;
                2, 3:    alusignal = DIV;
                default: alusignal = 4'($urandom());
            endcase
            a       = pick();
            b       = pick();
            flush   = ($urandom_range(0, 79) == 0);
            mthi_we = ($urandom_range(0, 9) == 0);
            mtlo_we = ($urandom_range(0, 9) == 0);
            wdata   = $urandom();
            rst_n   = ($urandom_range(0, 599) != 0);
            tick();
        end
        set_idle();
        rst_n = 1'b1;
        wait_idle(n);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
